// File: rtl/banco_reg_pkg.sv
// Shared definitions for the multi-port register bank.
// Holds the clear-FSM state encoding, the default parameter values and a
// constant log2 helper used to size address ports.
package banco_reg_pkg;

  typedef enum logic [0:0] {
    LIMPANDO = 1'b0,
    PRONTO   = 1'b1
  } estado_t;

  localparam int unsigned LARGURA_PADRAO     = 64;
  localparam int unsigned NUM_REGS_PADRAO    = 32;
  localparam int unsigned NUM_LEITURA_PADRAO = 2;

  // Ceiling log2; valid for valor >= 2 (the bank never has fewer registers).
  function automatic int unsigned log2(input int unsigned valor);
    log2 = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(valor)) log2 = i + 1;
    end
  endfunction

endpackage

// File: rtl/banco_reg_placar.sv
// Per-register busy scoreboard for the issue logic.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset (clears all busy bits)
//   habilita              bank initialised; gates updates and forces ocupado to 0
//   escrita_en/endereco_escrita   write-back: clears the busy bit
//   reserva_en/endereco_reserva   issue: sets the busy bit (wins over a same-cycle clear)
//   endereco_leitura      packed read addresses, port p at [p*AW +: AW]
//   ocupado               busy flag seen by each read port
module banco_reg_placar
  import banco_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS    = NUM_REGS_PADRAO,
  parameter int unsigned NUM_LEITURA = NUM_LEITURA_PADRAO,
  parameter bit          ZERO_R0     = 1'b1,
  parameter bit          BYPASS      = 1'b1,
  localparam int unsigned AW         = log2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      habilita,
  input  logic                      escrita_en,
  input  logic [AW-1:0]             endereco_escrita,
  input  logic                      reserva_en,
  input  logic [AW-1:0]             endereco_reserva,
  input  logic [NUM_LEITURA*AW-1:0] endereco_leitura,
  output logic [NUM_LEITURA-1:0]    ocupado
);

  logic [NUM_REGS-1:0] ocupado_q, ocupado_d;
  logic                esc_ok, res_ok;

  assign esc_ok = habilita & escrita_en & ~(ZERO_R0 & (endereco_escrita == '0));
  assign res_ok = habilita & reserva_en & ~(ZERO_R0 & (endereco_reserva == '0));

  // Set applied after clear: a new producer issued in the write-back cycle keeps it busy.
  always_comb begin
    ocupado_d = ocupado_q;
    if (esc_ok) ocupado_d[endereco_escrita] = 1'b0;
    if (res_ok) ocupado_d[endereco_reserva] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ocupado_q <= '0;
    else          ocupado_q <= ocupado_d;
  end

  for (genvar p = 0; p < NUM_LEITURA; p++) begin : g_porta
    logic [AW-1:0] end_p;
    logic          limpa_ja;
    assign end_p    = endereco_leitura[p*AW +: AW];
    // Forward a same-cycle write-back, unless a reservation re-marks the register.
    assign limpa_ja = BYPASS & esc_ok & (endereco_escrita == end_p) &
                      ~(res_ok & (endereco_reserva == end_p));
    assign ocupado[p] = habilita & ocupado_q[end_p] & ~limpa_ja &
                        ~(ZERO_R0 & (end_p == '0));
  end

endmodule

// File: rtl/banco_reg_multi.sv
// Parametrised multi-port register bank with hardware clear sequencer,
// optional write-to-read bypass and busy scoreboard.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   escrita_en, endereco_regd, dado_escrita   write-back port
//   reserva_en, endereco_reserva              mark register busy at issue
//   endereco_leitura   packed read addresses, port p at [p*AW +: AW]
//   valor_leitura      packed read data, port p at [p*LARGURA +: LARGURA]
//   ocupado            busy flag of each addressed register
//   pronto             clear finished; bank accepts writes and reservations
module banco_reg_multi
  import banco_reg_pkg::*;
#(
  parameter int unsigned LARGURA     = LARGURA_PADRAO,
  parameter int unsigned NUM_REGS    = NUM_REGS_PADRAO,
  parameter int unsigned NUM_LEITURA = NUM_LEITURA_PADRAO,
  parameter bit          ZERO_R0     = 1'b1,
  parameter bit          BYPASS      = 1'b1,
  localparam int unsigned AW         = log2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           escrita_en,
  input  logic [AW-1:0]                  endereco_regd,
  input  logic [LARGURA-1:0]             dado_escrita,
  input  logic                           reserva_en,
  input  logic [AW-1:0]                  endereco_reserva,
  input  logic [NUM_LEITURA*AW-1:0]      endereco_leitura,
  output logic [NUM_LEITURA*LARGURA-1:0] valor_leitura,
  output logic [NUM_LEITURA-1:0]         ocupado,
  output logic                           pronto
);

  estado_t            estado_q, estado_d;
  logic [AW-1:0]      contador_q, contador_d;
  logic [LARGURA-1:0] regs_q [NUM_REGS];
  logic               escrita_ok;

  assign pronto     = (estado_q == PRONTO);
  assign escrita_ok = pronto & escrita_en & ~(ZERO_R0 & (endereco_regd == '0));

  // Clear sequencer: one register per cycle, stops at the last one.
  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    case (estado_q)
      LIMPANDO: begin
        if (contador_q == AW'(NUM_REGS - 1)) estado_d = PRONTO;
        else                                 contador_d = contador_q + AW'(1);
      end
      PRONTO:  ;
      default: estado_d = LIMPANDO;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q   <= LIMPANDO;
      contador_q <= '0;
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
    end
  end

  // Storage has no reset; the clear sequencer zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (!pronto)         regs_q[contador_q]    <= '0;
    else if (escrita_ok) regs_q[endereco_regd] <= dado_escrita;
  end

  for (genvar p = 0; p < NUM_LEITURA; p++) begin : g_leitura
    logic [AW-1:0] end_p;
    assign end_p = endereco_leitura[p*AW +: AW];
    assign valor_leitura[p*LARGURA +: LARGURA] =
        (!pronto || (ZERO_R0 && (end_p == '0)))         ? '0 :
        (BYPASS && escrita_ok && (endereco_regd == end_p)) ? dado_escrita :
                                                             regs_q[end_p];
  end

  banco_reg_placar #(
    .NUM_REGS    (NUM_REGS),
    .NUM_LEITURA (NUM_LEITURA),
    .ZERO_R0     (ZERO_R0),
    .BYPASS      (BYPASS)
  ) u_placar (
    .clk              (clk),
    .reset_n          (reset_n),
    .habilita         (pronto),
    .escrita_en       (escrita_en),
    .endereco_escrita (endereco_regd),
    .reserva_en       (reserva_en),
    .endereco_reserva (endereco_reserva),
    .endereco_leitura (endereco_leitura),
    .ocupado          (ocupado)
  );

endmodule

// File: tb/tb_banco_reg_multi.sv
module tb_banco_reg_multi;

  localparam logic [63:0] D = 64'hDEAD_BEEF_0000_0001;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the default bank (bypass) and the no-bypass bank.
  logic         escrita_en, reserva_en;
  logic [4:0]   endereco_regd, endereco_reserva;
  logic [63:0]  dado_escrita;
  logic [9:0]   endereco_leitura;
  logic [127:0] val_b, val_n;
  logic [1:0]   oc_b, oc_n;
  logic         pr_b, pr_n;

  // Small bank: 8 x 32, four read ports.
  logic         e2_we, e2_re;
  logic [2:0]   e2_wa, e2_ra;
  logic [31:0]  e2_wd;
  logic [11:0]  e2_rd;
  logic [127:0] e2_val;
  logic [3:0]   e2_oc;
  logic         e2_pr;

  int total = 0;
  int bad   = 0;

  banco_reg_multi dut_b (
    .clk(clk), .reset_n(reset_n), .escrita_en(escrita_en), .endereco_regd(endereco_regd),
    .dado_escrita(dado_escrita), .reserva_en(reserva_en), .endereco_reserva(endereco_reserva),
    .endereco_leitura(endereco_leitura), .valor_leitura(val_b), .ocupado(oc_b), .pronto(pr_b)
  );

  banco_reg_multi #(.BYPASS(1'b0)) dut_n (
    .clk(clk), .reset_n(reset_n), .escrita_en(escrita_en), .endereco_regd(endereco_regd),
    .dado_escrita(dado_escrita), .reserva_en(reserva_en), .endereco_reserva(endereco_reserva),
    .endereco_leitura(endereco_leitura), .valor_leitura(val_n), .ocupado(oc_n), .pronto(pr_n)
  );

  banco_reg_multi #(.LARGURA(32), .NUM_REGS(8), .NUM_LEITURA(4)) dut_4 (
    .clk(clk), .reset_n(reset_n), .escrita_en(e2_we), .endereco_regd(e2_wa),
    .dado_escrita(e2_wd), .reserva_en(e2_re), .endereco_reserva(e2_ra),
    .endereco_leitura(e2_rd), .valor_leitura(e2_val), .ocupado(e2_oc), .pronto(e2_pr)
  );

  task automatic check(input string nome, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nome, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  a0, a1;
    logic [63:0] bv0, bv1;
    logic [1:0]  boc;
    logic [63:0] nv0, nv1;
    logic [1:0]  noc;
  } vetor_t;

  vetor_t tab[14];

  initial begin
    //         we  wa  wd                     re  ra  a0  a1  bv0   bv1   boc    nv0   nv1   noc
    tab[0]  = '{1, 7, D,                      0,  0,  5,  7,  0,    D,    2'b00, 0,    0,    2'b00};
    tab[1]  = '{0, 0, 0,                      0,  0,  5,  7,  0,    D,    2'b00, 0,    D,    2'b00};
    tab[2]  = '{1, 0, 64'hFFFF_FFFF_FFFF_FFFF,1,  0,  0,  0,  0,    0,    2'b00, 0,    0,    2'b00};
    tab[3]  = '{0, 0, 0,                      1,  3,  3,  3,  0,    0,    2'b00, 0,    0,    2'b00};
    tab[4]  = '{0, 0, 0,                      0,  0,  3,  3,  0,    0,    2'b11, 0,    0,    2'b11};
    tab[5]  = '{1, 3, 64'h33,                 0,  0,  3,  3,  'h33, 'h33, 2'b00, 0,    0,    2'b11};
    tab[6]  = '{0, 0, 0,                      0,  0,  3,  3,  'h33, 'h33, 2'b00, 'h33, 'h33, 2'b00};
    tab[7]  = '{1, 3, 64'h44,                 1,  3,  3,  7,  'h44, D,    2'b00, 'h33, D,    2'b00};
    tab[8]  = '{0, 0, 0,                      0,  0,  3,  7,  'h44, D,    2'b01, 'h44, D,    2'b01};
    tab[9]  = '{0, 0, 0,                      1,  7,  7,  3,  D,    'h44, 2'b10, D,    'h44, 2'b10};
    tab[10] = '{1, 7, 64'h77,                 0,  0,  7,  7,  'h77, 'h77, 2'b00, D,    D,    2'b11};
    tab[11] = '{0, 0, 0,                      0,  0,  7,  0,  'h77, 0,    2'b00, 'h77, 0,    2'b00};
    tab[12] = '{1, 3, 64'h55,                 1,  3,  3,  3,  'h55, 'h55, 2'b11, 'h44, 'h44, 2'b11};
    tab[13] = '{0, 0, 0,                      0,  0,  3,  3,  'h55, 'h55, 2'b11, 'h55, 'h55, 2'b11};

    // Writes and reservations to reg 5 held active throughout the clear.
    escrita_en = 1'b1; endereco_regd = 5'd5; dado_escrita = 64'hAAAA_AAAA_AAAA_AAAA;
    reserva_en = 1'b1; endereco_reserva = 5'd5; endereco_leitura = {5'd5, 5'd5};
    e2_we = 1'b0; e2_wa = '0; e2_wd = '0; e2_re = 1'b0; e2_ra = '0; e2_rd = '0;

    #12;
    check("reset_pronto", pr_b, 1'b0);
    check("reset_valor", val_b, '0);
    check("reset_ocupado", oc_b, '0);
    reset_n = 1'b1;

    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      check("pronto_clear", pr_b, (i == 32));
      if (i <= 8) check("pronto_clear_8regs", e2_pr, (i == 8));
      if (i < 32) check("valor_during_clear", val_b, '0);
    end
    check("pronto_nobypass", pr_n, 1'b1);
    escrita_en = 1'b0;
    reserva_en = 1'b0;

    foreach (tab[k]) begin
      escrita_en = tab[k].we; endereco_regd = tab[k].wa; dado_escrita = tab[k].wd;
      reserva_en = tab[k].re; endereco_reserva = tab[k].ra;
      endereco_leitura = {tab[k].a1, tab[k].a0};
      #3;
      check($sformatf("vec%0d_bypass_valor", k), val_b, {tab[k].bv1, tab[k].bv0});
      check($sformatf("vec%0d_bypass_ocupado", k), oc_b, tab[k].boc);
      check($sformatf("vec%0d_nobypass_valor", k), val_n, {tab[k].nv1, tab[k].nv0});
      check($sformatf("vec%0d_nobypass_ocupado", k), oc_n, tab[k].noc);
      @(posedge clk); #1;
    end
    escrita_en = 1'b0;
    reserva_en = 1'b0;

    // Four-port bank.
    e2_we = 1'b1; e2_wa = 3'd1; e2_wd = 32'h11;
    @(posedge clk); #1;
    e2_wa = 3'd2; e2_wd = 32'h22;
    @(posedge clk); #1;
    e2_wa = 3'd7; e2_wd = 32'h77;
    @(posedge clk); #1;
    e2_we = 1'b0;
    e2_rd = {3'd7, 3'd1, 3'd2, 3'd1};
    #3;
    check("four_port_valor", e2_val, {32'h77, 32'h11, 32'h22, 32'h11});
    check("four_port_ocupado", e2_oc, 4'b0000);

    // Reset mid-operation with reg 9 busy and holding data.
    @(posedge clk); #1;
    escrita_en = 1'b1; endereco_regd = 5'd9; dado_escrita = 64'h99;
    reserva_en = 1'b1; endereco_reserva = 5'd9;
    @(posedge clk); #1;
    escrita_en = 1'b0; reserva_en = 1'b0;
    endereco_leitura = {5'd9, 5'd9};
    #2;
    check("reg9_before_reset", val_b, {64'h99, 64'h99});
    check("reg9_busy_before_reset", oc_b, 2'b11);
    reset_n = 1'b0;
    #1;
    check("async_reset_pronto", pr_b, 1'b0);
    check("async_reset_valor", val_b, '0);
    check("async_reset_ocupado", oc_b, '0);
    check("async_reset_pronto_8regs", e2_pr, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      check("pronto_partial_clear", pr_b, 1'b0);
    end
    reset_n = 1'b0;
    #1;
    check("midclear_reset_pronto", pr_b, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      check("pronto_restart_clear", pr_b, (i == 32));
    end
    #2;
    check("reg9_after_restart", val_b, '0);
    check("reg9_busy_after_restart", oc_b, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
